// File: rtl/ines_pkg.sv
// Shared types and constants for the iNES ROM loader.
package ines_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_TRAINER,
        ST_PRG,
        ST_CHR,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef struct packed {
        logic [7:0] prgBanks;
        logic [7:0] chrBanks;
        logic [7:0] mapper;
        logic       mirror;
        logic       trainer;
    } ines_header_t;

    localparam logic [31:0] INES_MAGIC     = 32'h1A53454E;
    localparam int unsigned PRG_BANK_BYTES = 16384;
    localparam int unsigned CHR_BANK_BYTES = 8192;
    localparam int unsigned TRAINER_BYTES  = 512;

    // States in which the stream is open for bytes.
    function automatic logic takesBytes(input loader_state_t s);
        return (s == ST_HEADER) || (s == ST_TRAINER) || (s == ST_PRG) || (s == ST_CHR);
    endfunction

endpackage

// File: rtl/ines_header_parser.sv
// Captures the 16-byte iNES header, checks the magic and the PRG/CHR sizes
// against the BRAM region capacities.
module ines_header_parser
    import ines_pkg::*;
#(
    parameter int unsigned NUM_COL   = 4,
    parameter int unsigned PRG_WORDS = 16384,
    parameter int unsigned CHR_WORDS = 16384
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         accept,
    input  logic [7:0]   data,
    output ines_header_t hdr,
    output logic         hdrOk,
    output logic         hdrErr
);

    localparam int unsigned PRG_CAP = PRG_WORDS * 4 / NUM_COL;
    localparam int unsigned CHR_CAP = CHR_WORDS * 4 / NUM_COL;

    logic [3:0] idx;
    logic       magicBad;
    logic       sizeBad;

    always_comb begin
        magicBad = (idx < 4'd4) && (data != INES_MAGIC[{idx[1:0], 3'b000} +: 8]);
        sizeBad  = (hdr.prgBanks == 8'd0)
                || (32'(hdr.prgBanks) * 32'd4096 > PRG_CAP)
                || (32'(hdr.chrBanks) * 32'd2048 > CHR_CAP);
        hdrErr   = accept && (magicBad || ((idx == 4'd15) && sizeBad));
        hdrOk    = accept && (idx == 4'd15) && !sizeBad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            hdr <= '0;
        end else if (clear) begin
            idx <= '0;
            hdr <= '0;
        end else if (accept) begin
            idx <= idx + 4'd1;
            case (idx)
                4'd4: hdr.prgBanks <= data;
                4'd5: hdr.chrBanks <= data;
                4'd6: begin
                    hdr.mapper[3:0] <= data[7:4];
                    hdr.mirror      <= data[0];
                    hdr.trainer     <= data[2];
                end
                4'd7: hdr.mapper[7:4] <= data[7:4];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ines_rom_loader.sv
// Streaming iNES loader: header parse, then PRG/CHR bytes into BRAM byte lanes.
// Build option INES_TRAINER_EN: skip a 512-byte trainer instead of rejecting it.
module ines_rom_loader
    import ines_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned PRG_BASE   = 0,
    parameter int unsigned CHR_BASE   = 2**(ADDR_WIDTH-1),
    parameter int unsigned PRG_WORDS  = 2**(ADDR_WIDTH-1),
    parameter int unsigned CHR_WORDS  = 2**(ADDR_WIDTH-1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          bram_en,
    output logic [NUM_COL-1:0]            bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [NUM_COL*COL_WIDTH-1:0]  bram_din,
    output logic                          done,
    output logic                          error,
    output logic [7:0]                    prg_banks,
    output logic [7:0]                    chr_banks,
    output logic [7:0]                    mapper,
    output logic                          mirror
);

    localparam int unsigned LANE_BITS = $clog2(NUM_COL);
    localparam logic [21:0] LANE_MASK = 22'(NUM_COL - 1);

    loader_state_t   state, nxt;
    ines_header_t    hdr;
    logic            readyQ;
    logic            accept, wrAcc;
    logic            hdrOk, hdrErr;
    logic [21:0]     bodyCnt;
    logic [21:0]     prgLast, chrLast;
    logic [ADDR_WIDTH-1:0] regionBase;

    // start masks the handshake so a coinciding byte is left in the stream.
    assign s_ready = readyQ && !start;
    assign accept  = s_valid && s_ready;
    assign wrAcc   = accept && ((state == ST_PRG) || (state == ST_CHR));

    assign prgLast    = 22'(32'(hdr.prgBanks) * PRG_BANK_BYTES - 32'd1);
    assign chrLast    = 22'(32'(hdr.chrBanks) * CHR_BANK_BYTES - 32'd1);
    assign regionBase = (state == ST_CHR) ? ADDR_WIDTH'(CHR_BASE) : ADDR_WIDTH'(PRG_BASE);

    assign prg_banks = hdr.prgBanks;
    assign chr_banks = hdr.chrBanks;
    assign mapper    = hdr.mapper;
    assign mirror    = hdr.mirror;

    ines_header_parser #(
        .NUM_COL   (NUM_COL),
        .PRG_WORDS (PRG_WORDS),
        .CHR_WORDS (CHR_WORDS)
    ) uParser (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .accept (accept && (state == ST_HEADER)),
        .data   (s_data),
        .hdr    (hdr),
        .hdrOk  (hdrOk),
        .hdrErr (hdrErr)
    );

`ifdef INES_TRAINER_EN
    logic [8:0] trnCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  trnCnt <= '0;
        else if (state != ST_TRAINER) trnCnt <= '0;
        else if (accept)             trnCnt <= trnCnt + 9'd1;
    end
`endif

    always_comb begin
        nxt = state;
        if (start) begin
            nxt = ST_HEADER;
        end else begin
            case (state)
                ST_HEADER: begin
                    if (hdrErr)
                        nxt = ST_ERROR;
`ifdef INES_TRAINER_EN
                    else if (hdrOk)
                        nxt = hdr.trainer ? ST_TRAINER : ST_PRG;
`else
                    else if (hdrOk)
                        nxt = hdr.trainer ? ST_ERROR : ST_PRG;
`endif
                end
`ifdef INES_TRAINER_EN
                ST_TRAINER:
                    if (accept && trnCnt == 9'(TRAINER_BYTES - 1))
                        nxt = ST_PRG;
`endif
                ST_PRG:
                    if (accept && bodyCnt == prgLast)
                        nxt = (hdr.chrBanks == 8'd0) ? ST_DONE : ST_CHR;
                ST_CHR:
                    if (accept && bodyCnt == chrLast)
                        nxt = ST_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            readyQ  <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            bodyCnt <= '0;
        end else begin
            state  <= nxt;
            readyQ <= takesBytes(nxt);
            done   <= (nxt == ST_DONE);
            error  <= (nxt == ST_ERROR);
            if (nxt != state)
                bodyCnt <= '0;
            else if (accept)
                bodyCnt <= bodyCnt + 22'd1;
        end
    end

    // Header checks bound the body size, so the word offset never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_en <= wrAcc;
            bram_we <= wrAcc ? (NUM_COL'(1) << (bodyCnt & LANE_MASK)) : '0;
            if (wrAcc) begin
                bram_addr <= regionBase + ADDR_WIDTH'(bodyCnt >> LANE_BITS);
                bram_din  <= (NUM_COL*COL_WIDTH)'({NUM_COL{s_data}});
            end
        end
    end

endmodule
